// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - operand/result handshake bundle for muldiv_unit
//
// Signals:
//   in_valid/in_ready  - operation offer / unit idle
//   op, a, b           - operation code and rs1/rs2 operands
//   flush              - kill any in-flight operation
//   out_valid/out_ready- result offer / consumer take
//   res                - result
// Modports: master (pipeline side), slave (muldiv_unit side).

interface muldiv_unit_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] res;

  modport master (
    output in_valid, op, a, b, flush, out_ready,
    input  in_ready, out_valid, res
  );

  modport slave (
    input  in_valid, op, a, b, flush, out_ready,
    output in_ready, out_valid, res
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative radix-2 multiply / restoring divide unit
//
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - muldiv_unit_if.slave: in_valid/in_ready, op, a, b, flush,
//         out_valid/out_ready, res
// Build option:
//   MULDIV_W_OPS_EN - decode the 32-bit W ops (needs XLEN = 64); without it
//                     W codes return 0 through the fast path.

module muldiv_unit #(
  parameter int XLEN = 64
) (
  input logic          clk,
  input logic          rst,
  muldiv_unit_if.slave bus
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;

  // hi/lo hold {accumulator, multiplier} for multiply and
  // {remainder, dividend/quotient} for divide; opd is multiplicand/divisor.
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] hi_q, lo_q, opd_q, res_q;
  logic            div_q, sel_q, neg_q;
`ifdef MULDIV_W_OPS_EN
  logic            w_q, op_w;
  logic [31:0]     w_raw, w_res;
`endif

  // sel: high product half for MULH*, remainder for REM*
  logic is_mul, is_div, sgn_a, sgn_b, op_sel;
  always_comb begin
    is_mul = 1'b0;
    is_div = 1'b0;
    sgn_a  = 1'b0;
    sgn_b  = 1'b0;
    op_sel = 1'b0;
`ifdef MULDIV_W_OPS_EN
    op_w   = 1'b0;
`endif
    case (bus.op)
      4'b0000: is_mul = 1'b1;
      4'b0001: begin is_mul = 1'b1; op_sel = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; end
      4'b0010: begin is_mul = 1'b1; op_sel = 1'b1; sgn_a = 1'b1; end
      4'b0011: begin is_mul = 1'b1; op_sel = 1'b1; end
      4'b0100: begin is_div = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; end
      4'b0101: is_div = 1'b1;
      4'b0110: begin is_div = 1'b1; op_sel = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; end
      4'b0111: begin is_div = 1'b1; op_sel = 1'b1; end
`ifdef MULDIV_W_OPS_EN
      4'b1000: begin is_mul = 1'b1; op_w = 1'b1; end
      4'b1100: begin is_div = 1'b1; op_w = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; end
      4'b1101: begin is_div = 1'b1; op_w = 1'b1; end
      4'b1110: begin is_div = 1'b1; op_w = 1'b1; op_sel = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; end
      4'b1111: begin is_div = 1'b1; op_w = 1'b1; op_sel = 1'b1; end
`endif
      default: ;
    endcase
  end

  // Operand magnitudes and fast-path detection at the active width.
  // a_ext is the dividend as it must appear in res (sign-extended for W).
  logic            a_neg, b_neg, b_zero, ovf, fast;
  logic [XLEN-1:0] mag_a, mag_b, a_ext, fast_res;
  always_comb begin
    a_neg  = sgn_a & bus.a[XLEN-1];
    b_neg  = sgn_b & bus.b[XLEN-1];
    mag_a  = a_neg ? -bus.a : bus.a;
    mag_b  = b_neg ? -bus.b : bus.b;
    a_ext  = bus.a;
    b_zero = (bus.b == '0);
    ovf    = is_div && sgn_b && (bus.a == MOST_NEG) && (bus.b == '1);
`ifdef MULDIV_W_OPS_EN
    if (op_w) begin
      a_neg  = sgn_a & bus.a[31];
      b_neg  = sgn_b & bus.b[31];
      mag_a  = {{(XLEN-32){1'b0}}, (a_neg ? -bus.a[31:0] : bus.a[31:0])};
      mag_b  = {{(XLEN-32){1'b0}}, (b_neg ? -bus.b[31:0] : bus.b[31:0])};
      a_ext  = {{(XLEN-32){bus.a[31]}}, bus.a[31:0]};
      b_zero = (bus.b[31:0] == 32'd0);
      ovf    = is_div && sgn_b && (bus.a[31:0] == 32'h8000_0000) && (bus.b[31:0] == 32'hFFFF_FFFF);
    end
`endif
    fast     = 1'b0;
    fast_res = '0;
    if (!(is_mul || is_div)) begin
      fast = 1'b1;
    end else if (is_div && b_zero) begin
      fast     = 1'b1;
      fast_res = op_sel ? a_ext : '1;
    end else if (ovf) begin
      fast     = 1'b1;
      fast_res = op_sel ? '0 : a_ext;
    end
  end

  logic accept;
  assign accept = (state_q == IDLE) && bus.in_valid && !bus.flush;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = fast ? DONE : BUSY;
      BUSY:    if (cnt_q == '0) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.flush) state_d = IDLE;
  end

  // One iteration: shift-add step or restoring subtract step.
  logic [XLEN:0]   mul_sum, div_rs, div_diff;
  logic [XLEN-1:0] hi_n, lo_n;
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
    div_rs   = {hi_q, lo_q[XLEN-1]};
    div_diff = div_rs - {1'b0, opd_q};
    if (div_q) begin
      hi_n = div_diff[XLEN] ? div_rs[XLEN-1:0] : div_diff[XLEN-1:0];
      lo_n = {lo_q[XLEN-2:0], ~div_diff[XLEN]};
    end else begin
      hi_n = mul_sum[XLEN:1];
      lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  // Result of the last iteration with sign correction. Negating the high
  // half of a 2N-bit product needs the borrow from the low half.
  logic [XLEN-1:0] fin_raw, fin_res;
  always_comb begin
    fin_raw = sel_q ? hi_n : lo_n;
    if (!neg_q)                fin_res = fin_raw;
    else if (!div_q && sel_q)  fin_res = ~hi_n + XLEN'(lo_n == '0);
    else                       fin_res = -fin_raw;
`ifdef MULDIV_W_OPS_EN
    // 32 shifts leave the low product word in lo[63:32]; a divide loaded
    // with the dividend in lo[63:32] ends with the quotient in lo[31:0].
    w_raw = div_q ? (sel_q ? hi_n[31:0] : lo_n[31:0]) : lo_n[XLEN-1:32];
    w_res = neg_q ? -w_raw : w_raw;
    if (w_q) fin_res = {{(XLEN-32){w_res[31]}}, w_res};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      opd_q <= '0;
      res_q <= '0;
      div_q <= 1'b0;
      sel_q <= 1'b0;
      neg_q <= 1'b0;
`ifdef MULDIV_W_OPS_EN
      w_q   <= 1'b0;
`endif
    end else if (bus.flush) begin
      cnt_q <= '0;
    end else if (accept) begin
      div_q <= is_div;
      sel_q <= op_sel;
      neg_q <= (is_div && op_sel) ? a_neg : (a_neg ^ b_neg);
      hi_q  <= '0;
      cnt_q <= CW'(XLEN - 1);
      lo_q  <= is_div ? mag_a : mag_b;
      opd_q <= is_div ? mag_b : mag_a;
`ifdef MULDIV_W_OPS_EN
      w_q   <= op_w;
      if (op_w) begin
        cnt_q <= CW'(31);
        if (is_div) lo_q <= {mag_a[31:0], {(XLEN-32){1'b0}}};
      end
`endif
      if (fast) res_q <= fast_res;
    end else if (state_q == BUSY) begin
      hi_q <= hi_n;
      lo_q <= lo_n;
      if (cnt_q == '0) res_q <= fin_res;
      else             cnt_q <= cnt_q - CW'(1);
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.res       = res_q;

endmodule
